// File: rtl/riscv_muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide execute unit.
package riscv_muldiv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPrep = 2'd1,
    StCalc = 2'd2,
    StDone = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_prep.sv
// Operand magnitudes, result signs and divide special cases for the PREP cycle.
module muldiv_prep
  import riscv_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            res_neg,
  output logic            rem_neg,
  output logic            special,
  output logic [XLEN-1:0] special_result
);

  logic is_div, a_signed, b_signed, a_neg, b_neg, div_zero, ovf;

  always_comb begin
    is_div   = funct3[2];
    // Signed divides have funct3[0] clear; MULHSU only sign-extends rs1.
    a_signed = is_div ? ~funct3[0] : (funct3 == FUNCT3_MULH || funct3 == FUNCT3_MULHSU);
    b_signed = is_div ? ~funct3[0] : (funct3 == FUNCT3_MULH);
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    mag_a    = a_neg ? -a : a;
    mag_b    = b_neg ? -b : b;
    res_neg  = a_neg ^ b_neg;
    rem_neg  = is_div & a_neg;

    div_zero = is_div && (b == '0);
    ovf      = is_div && a_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special  = div_zero | ovf;

    special_result = '0;
    if (div_zero) begin
      special_result = funct3[1] ? a : '1;
    end else if (ovf) begin
      special_result = funct3[1] ? '0 : a;
    end
  end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M unit: shift-add multiply and restoring divide, one bit per CALC cycle.
module execute_muldiv_unit
  import riscv_muldiv_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ITERATIONS = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int unsigned CntW = $clog2(ITERATIONS);

  muldiv_state_e   state_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q, rd_out_q;
  logic [XLEN-1:0] a_q, b_q, d_q, result_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN:0]   rem_q;
  logic [CntW-1:0] cnt_q;
  logic            res_neg_q, rem_neg_q, done_q;

  logic [XLEN-1:0] mag_a, mag_b, special_result;
  logic            res_neg, rem_neg, special;

  muldiv_prep #(
    .XLEN(XLEN)
  ) u_prep (
    .funct3        (funct3_q),
    .a             (a_q),
    .b             (b_q),
    .mag_a         (mag_a),
    .mag_b         (mag_b),
    .res_neg       (res_neg),
    .rem_neg       (rem_neg),
    .special       (special),
    .special_result(special_result)
  );

  // Multiply: multiplier sits in acc low half and shifts out as the product shifts in.
  // Divide: acc low half holds dividend bits shifting into the quotient.
  logic [XLEN:0]     mul_sum, div_shift, div_trial, rem_step;
  logic [2*XLEN-1:0] acc_step, prod;
  logic [XLEN-1:0]   quot, remd, final_result;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, d_q} : '0);
    div_shift = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
    div_trial = div_shift - {1'b0, d_q};
    if (funct3_q[2]) begin
      acc_step = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_trial[XLEN]};
      rem_step = div_trial[XLEN] ? div_shift : div_trial;
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
      rem_step = rem_q;
    end

    prod = res_neg_q ? -acc_step : acc_step;
    quot = res_neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    remd = rem_neg_q ? -rem_step[XLEN-1:0] : rem_step[XLEN-1:0];
    case (funct3_q)
      FUNCT3_MUL:                               final_result = prod[XLEN-1:0];
      FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: final_result = prod[2*XLEN-1:XLEN];
      FUNCT3_DIV, FUNCT3_DIVU:                  final_result = quot;
      default:                                  final_result = remd;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      funct3_q  <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      d_q       <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else if (flush_i) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            funct3_q <= funct3_i;
            rd_q     <= rd_i;
            a_q      <= operand_a_i;
            b_q      <= operand_b_i;
            state_q  <= StPrep;
          end
        end
        StPrep: begin
          if (special) begin
            result_q <= special_result;
            rd_out_q <= rd_q;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end else begin
            d_q       <= funct3_q[2] ? mag_b : mag_a;
            acc_q     <= {{XLEN{1'b0}}, funct3_q[2] ? mag_a : mag_b};
            rem_q     <= '0;
            res_neg_q <= res_neg;
            rem_neg_q <= rem_neg;
            cnt_q     <= '0;
            state_q   <= StCalc;
          end
        end
        StCalc: begin
          acc_q <= acc_step;
          rem_q <= rem_step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(ITERATIONS - 1)) begin
            result_q <= final_result;
            rd_out_q <= rd_q;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign stall_o  = ((state_q == StIdle) && start_i) || (state_q == StPrep) || (state_q == StCalc);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign rd_o     = rd_out_q;

endmodule
